// File: rtl/lcd1602_bus_ctrl.sv
// HD44780/1602 byte-write timing engine: takes one RS/data byte over valid/ready and
// drives RS/DB8/LCD_EN with programmable setup, enable, hold and execution waits.
//
// state      | meaning
// POWERUP    | waiting T_POWERUP cycles after reset before any write
// IDLE       | wr_ready high, waiting for the sequencer to present a byte
// SETUP      | RS/DB8 driven, LCD_EN low for T_SETUP cycles
// EN_HIGH    | LCD_EN high for T_EN_HIGH cycles
// HOLD       | LCD_EN low, RS/DB8 held for T_HOLD cycles
// WAIT       | controller execution time, short or long depending on the command
module lcd1602_bus_ctrl #(
  parameter int unsigned T_POWERUP    = 750000,
  parameter int unsigned T_SETUP      = 4,
  parameter int unsigned T_EN_HIGH    = 12,
  parameter int unsigned T_HOLD       = 4,
  parameter int unsigned T_WAIT_SHORT = 2000,
  parameter int unsigned T_WAIT_LONG  = 82000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk_lcd,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       LCD_EN,
  output logic       RS,
  output logic       RW,
  output logic [7:0] DB8
);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HIGH,
    ST_HOLD,
    ST_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] TC_POWERUP = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] TC_SETUP   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] TC_EN_HIGH = CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] TC_HOLD    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] TC_SHORT   = CNT_W'(T_WAIT_SHORT - 1);
  localparam logic [CNT_W-1:0] TC_LONG    = CNT_W'(T_WAIT_LONG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tc_wait;
  logic             long_q, long_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  assign tc_wait = long_q ? TC_LONG : TC_SHORT;

  always_ff @(posedge clk_lcd or negedge rst) begin
    if (!rst) begin
      state_q <= ST_POWERUP;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    long_d  = long_q;
    rs_d    = rs_q;
    db_d    = db_q;

    case (state_q)
      ST_POWERUP: if (cnt_q == TC_POWERUP) state_d = ST_IDLE;
      ST_IDLE: begin
        if (wr_valid && ready_q) begin
          state_d = ST_SETUP;
          rs_d    = wr_rs;
          db_d    = wr_data;
          // clear (0x01) and return-home (0x02/0x03) need the long execution wait
          long_d  = !wr_rs && (wr_data[7:2] == 6'b0);
        end
      end
      ST_SETUP:   if (cnt_q == TC_SETUP)   state_d = ST_EN_HIGH;
      ST_EN_HIGH: if (cnt_q == TC_EN_HIGH) state_d = ST_HOLD;
      ST_HOLD:    if (cnt_q == TC_HOLD)    state_d = ST_WAIT;
      ST_WAIT:    if (cnt_q == tc_wait)    state_d = ST_IDLE;
      default:    state_d = ST_POWERUP;
    endcase

    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;

    // outputs are registered from the next state so they change on the transition edge
    en_d    = (state_d == ST_EN_HIGH);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign wr_ready = ready_q;
  assign busy     = busy_q;
  assign LCD_EN   = en_q;
  assign RS       = rs_q;
  assign DB8      = db_q;
  assign RW       = 1'b0;

endmodule
